// File: rtl/wb_regfile_pkg.sv
// Shared writeback definitions: result-source encodings and datapath sizing.
package wb_regfile_pkg;
  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RESULTSRC_ALU = 2'b00,
    RESULTSRC_MEM = 2'b01,
    RESULTSRC_PC4 = 2'b10,
    RESULTSRC_ILL = 2'b11
  } resultsrc_e;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB inputs, decode read ports and writeback status outputs of the WB stage.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic                 regwrite_w;
  logic [1:0]           resultsrc_w;
  logic [XLEN-1:0]      aluresult_w;
  logic [XLEN-1:0]      readdata_w;
  logic [REG_IDX_W-1:0] rd_w;
  logic [XLEN-1:0]      pcplus4_w;
  logic [REG_IDX_W-1:0] rs1_d;
  logic [REG_IDX_W-1:0] rs2_d;
  logic [XLEN-1:0]      rd1_d;
  logic [XLEN-1:0]      rd2_d;
  logic [XLEN-1:0]      result_w;
  logic [31:0]          wb_count;
  logic                 illegal_src;

  modport master (
    output regwrite_w, resultsrc_w, aluresult_w, readdata_w, rd_w, pcplus4_w,
    output rs1_d, rs2_d,
    input  rd1_d, rd2_d, result_w, wb_count, illegal_src
  );

  modport slave (
    input  regwrite_w, resultsrc_w, aluresult_w, readdata_w, rd_w, pcplus4_w,
    input  rs1_d, rs2_d,
    output rd1_d, rd2_d, result_w, wb_count, illegal_src
  );
endinterface

// File: rtl/wb_regfile_regfile_2r1w.sv
// Two-read/one-write register array with hardwired-zero x0 and write-through bypass.
module regfile_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int NREG_P = NREG,
  parameter int IDX_W  = $clog2(NREG_P)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [XLEN_P-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr1,
  input  logic [IDX_W-1:0]  raddr2,
  output logic [XLEN_P-1:0] rdata1,
  output logic [XLEN_P-1:0] rdata2
);
  logic [XLEN_P-1:0] regs_q [NREG_P];
  logic [XLEN_P-1:0] regs_d [NREG_P];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // we is already qualified by reset at the top, so bypass is inactive during reset.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (we && (raddr1 == waddr)) ? wdata : regs_q[raddr1];
    if (raddr2 != '0) rdata2 = (we && (raddr2 == waddr)) ? wdata : regs_q[raddr2];
  end
endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, commit qualification, retired-write count, illegal flag.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  logic [XLEN-1:0] result;
  logic            commit;
  logic            illegal_seen;
  logic [31:0]     wb_count_q, wb_count_d;
  logic            illegal_q, illegal_d;

  always_comb begin
    result = '0;
    case (bus.resultsrc_w)
      RESULTSRC_ALU: result = bus.aluresult_w;
      RESULTSRC_MEM: result = bus.readdata_w;
      RESULTSRC_PC4: result = bus.pcplus4_w;
      default:       result = '0;
    endcase
  end

  always_comb begin
    illegal_seen = bus.regwrite_w && (bus.resultsrc_w == RESULTSRC_ILL);
    commit       = bus.regwrite_w && (bus.rd_w != '0) && !illegal_seen && !rst;
    wb_count_d   = wb_count_q + {31'd0, commit};
    illegal_d    = illegal_q | illegal_seen;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_count_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      wb_count_q <= wb_count_d;
      illegal_q  <= illegal_d;
    end
  end

  regfile_2r1w #(
    .XLEN_P (XLEN),
    .NREG_P (NREG),
    .IDX_W  (REG_IDX_W)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (commit),
    .waddr  (bus.rd_w),
    .wdata  (result),
    .raddr1 (bus.rs1_d),
    .raddr2 (bus.rs2_d),
    .rdata1 (bus.rd1_d),
    .rdata2 (bus.rd2_d)
  );

  assign bus.result_w    = result;
  assign bus.wb_count    = wb_count_q;
  assign bus.illegal_src = illegal_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed scenarios plus randomized traffic vs. a register model.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst;
  wb_regfile_if bus ();

  wb_regfile dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd1, rd2, res, cnt;
    logic        ill;
    bit          known;
    string       nm;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  logic        m_ill;
  bit          m_known = 0;

  function automatic logic [31:0] sel(logic [1:0] s, logic [31:0] a, logic [31:0] l, logic [31:0] p);
    if (s == 2'd0) return a;
    if (s == 2'd1) return l;
    if (s == 2'd2) return p;
    return 32'd0;
  endfunction

  task automatic chk(string nm, string fld, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s.%s got %h want %h", nm, fld, got, want);
    end
  endtask

  // Monitor: every cycle presents one combinational response, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.nm, "result_w", bus.result_w, e.res);
      if (e.known) begin
        chk(e.nm, "rd1_d", bus.rd1_d, e.rd1);
        chk(e.nm, "rd2_d", bus.rd2_d, e.rd2);
        chk(e.nm, "wb_count", bus.wb_count, e.cnt);
        chk(e.nm, "illegal_src", {31'd0, bus.illegal_src}, {31'd0, e.ill});
      end
    end
  end

  task automatic cyc(input logic r, input logic we, input logic [1:0] src,
                     input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input string nm);
    exp_t e;
    logic [31:0] res;
    bit commit;
    rst = r;
    bus.regwrite_w = we; bus.resultsrc_w = src;
    bus.aluresult_w = alu; bus.readdata_w = ld; bus.pcplus4_w = pc4;
    bus.rd_w = rd; bus.rs1_d = rs1; bus.rs2_d = rs2;
    res    = sel(src, alu, ld, pc4);
    commit = we && (rd != 0) && (src != 2'b11) && !r;
    e.nm = nm; e.res = res; e.known = m_known; e.cnt = m_cnt; e.ill = m_ill;
    e.rd1 = (rs1 == 0) ? 32'd0 : (commit && rs1 == rd) ? res : m_regs[rs1];
    e.rd2 = (rs2 == 0) ? 32'd0 : (commit && rs2 == rd) ? res : m_regs[rs2];
    sb_q.push_back(e);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 0; m_ill = 0; m_known = 1;
    end else begin
      if (commit) begin
        m_regs[rd] = res;
        m_cnt = m_cnt + 32'd1;
      end
      if (we && src == 2'b11) m_ill = 1;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] rs1, input logic [4:0] rs2, input string nm);
    cyc(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, rs1, rs2, nm);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 0; m_ill = 0;
    rst = 1'b1;
    bus.regwrite_w = 0; bus.resultsrc_w = 0; bus.aluresult_w = 0; bus.readdata_w = 0;
    bus.pcplus4_w = 0; bus.rd_w = 0; bus.rs1_d = 0; bus.rs2_d = 0;
    @(posedge clk); #1;

    // Reset with a pending write that must be dropped
    repeat (2) cyc(1, 1, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5, "reset");
    idle(5'd5, 5'd5, "post_reset");

    // Each result source
    cyc(0, 1, 2'b00, 32'h12345678, 32'h1111, 32'h2222, 5'd6, 5'd0, 5'd0, "src_alu");
    cyc(0, 1, 2'b01, 32'h3333, 32'h87654320, 32'h4444, 5'd14, 5'd6, 5'd0, "src_mem");
    cyc(0, 1, 2'b10, 32'h5555, 32'h6666, 32'hFF90F0FF, 5'd7, 5'd6, 5'd14, "src_pc4");
    idle(5'd6, 5'd14, "rb_6_14");
    idle(5'd7, 5'd7, "rb_7");

    // Bypass on both ports, then write to x0
    cyc(0, 1, 2'b00, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9, "bypass_x9");
    cyc(0, 1, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9, "write_x0");
    idle(5'd0, 5'd9, "after_x0");

    // Illegal source: flag sticks, only legal writes count
    cyc(0, 1, 2'b11, 32'hBAD0BAD0, 32'hBAD1, 32'hBAD2, 5'd3, 5'd3, 5'd0, "illegal");
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 2'b00, 32'h100 + i, 32'h0, 32'h0, 5'd20 + 5'(i), 5'd3, 5'd20, "post_illegal");
    idle(5'd3, 5'd24, "illegal_hold");
    cyc(0, 0, 2'b11, 32'h0, 32'h0, 32'h0, 5'd4, 5'd0, 5'd0, "ill_no_we");
    cyc(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd24, "rst_pulse");
    idle(5'd3, 5'd24, "illegal_cleared");
    cyc(0, 0, 2'b11, 32'h0, 32'h0, 32'h0, 5'd4, 5'd0, 5'd0, "ill_no_we2");

    // Counter wrap
    force dut.wb_count_q = 32'hFFFFFFFE;
    #1;
    release dut.wb_count_q;
    m_cnt = 32'hFFFFFFFE;
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 2'b00, 32'hC0DE0000 + i, 32'h0, 32'h0, 5'd11, 5'd11, 5'd0, "wrap");
    idle(5'd11, 5'd0, "wrap_end");

    // Randomized traffic, occasional reset
    for (int i = 0; i < 300; i++) begin
      logic [4:0] rd, rs1, rs2;
      rd  = 5'($urandom_range(0, 31));
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          $urandom, $urandom, $urandom, rd, rs1, rs2, "random");
    end

    // Reset in the middle of a write burst, landing on the x10 write
    for (int i = 1; i < 10; i++)
      cyc(0, 1, 2'($urandom_range(0, 2)), 32'hAB00 + i, 32'hCD00 + i, 32'hEF00 + i,
          5'(i), 5'(i), 5'(i - 1), "burst");
    cyc(1, 1, 2'b00, 32'h1, 32'h0, 32'h0, 5'd10, 5'd10, 5'd9, "burst_rst");
    for (int i = 0; i < 16; i++) idle(5'(2 * i), 5'(2 * i + 1), "zero_sweep");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage plus architectural register file for the 5-stage RV32I pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback result, and commits it into a 32×32 register file. Exposes two decode-stage read ports with same-cycle write-through bypass, the selected result for EX-stage forwarding, a retired-write counter and a sticky illegal-encoding flag.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `NREG`, 32: register count; index width is log2(`NREG`) = 5.

Ports:
- `clk`  in  1  Clock. All state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `regwrite_w`  in  1  Write enable from MEM/WB.
- `resultsrc_w`  in  2  Result select: 00 ALU, 01 load data, 10 PC+4, 11 illegal.
- `aluresult_w`  in  XLEN  ALU result.
- `readdata_w`  in  XLEN  Load data.
- `rd_w`  in  5  Destination register index.
- `pcplus4_w`  in  XLEN  Link address.
- `rs1_d`, `rs2_d`  in  5  Decode-stage source indices.
- `rd1_d`, `rd2_d`  out  XLEN  Decode-stage read data.
- `result_w`  out  XLEN  Selected writeback value, for the forwarding mux.
- `wb_count`  out  32  Number of committed register writes.
- `illegal_src`  out  1  Sticky: set on an attempted write with `resultsrc_w`=11.

## Operation
- Result mux, combinational: 00→`aluresult_w`, 01→`readdata_w`, 10→`pcplus4_w`, 11→0.
- Commit condition: `regwrite_w` & `rd_w`≠0 & `resultsrc_w`≠11 & !`rst`. On commit, `regs[rd_w]` ← `result_w` at the rising edge.
- x0: never written. Reads of index 0 return 0 unconditionally, including under bypass.
- Read ports are combinational. Bypass rule per port: if the commit condition holds and `rs_d`==`rd_w`, return `result_w`; otherwise return `regs[rs_d]`. This gives write-before-read semantics within one cycle, which removes the WB→ID hazard.
- `wb_count` increments by 1 on each committed write and wraps from 32'hFFFFFFFF to 0. Writes to x0 and illegal writes are not counted.
- `illegal_src` sets when `regwrite_w` & `resultsrc_w`==11 are seen and no reset is active. It stays set until `rst`. A value of 11 with `regwrite_w`=0 is ignored.

## Timing
- Reset: every `regs[i]`=0, `wb_count`=0, `illegal_src`=0, all effective at the first rising edge with `rst`=1. The read ports then return 0 for all indices, with no bypass active while `rst`=1.
- Reset mid-operation: a write presented in the same cycle as `rst` is dropped. Reset has priority over commit, count and flag updates.
- Write latency: the value is in the array at the edge ending cycle N. Bypass makes it visible on `rd1_d`/`rd2_d` during cycle N itself.
- `result_w` has zero latency and follows the inputs combinationally.
- Simultaneous cases:
  - `rs1_d`==`rs2_d`==`rd_w`: both ports bypass.
  - Back-to-back writes to the same `rd_w`: the last one wins, and the count increases by 2.
- No handshake. One writeback per cycle; the block never stalls.

## Structure
- Shared package/header `pipeline_defs`: `RESULTSRC_ALU`=2'b00, `RESULTSRC_MEM`=2'b01, `RESULTSRC_PC4`=2'b10, `RESULTSRC_ILL`=2'b11, and `XLEN`. `reg_mw` and the control decoder also use these.
- Sub-module `regfile_2r1w` holds the array, x0 masking and bypass, with a synchronous reset clear. The top level holds the result mux, commit qualification, `wb_count` and `illegal_src`.

## Test plan
- Reset: assert `rst` for 2 cycles with `regwrite_w`=1, `rd_w`=5, `aluresult_w`=32'hDEADBEEF. Required: `rd1_d`(rs1=5)=0, `wb_count`=0, `illegal_src`=0 after release.
- Source mux: write x6 with `resultsrc_w`=00 and ALU=32'h12345678, then x14 with 01 and load=32'h87654320, then x7 with 10 and pc4=32'hFF90F0FF. Read back on the following cycles. Required: exact values returned, `wb_count`=3.
- Bypass: in one cycle, write x9=32'hA5A5A5A5 with `rs1_d`=`rs2_d`=9. Required: `rd1_d`=`rd2_d`=32'hA5A5A5A5 in that same cycle. Also write x0=32'hFFFFFFFF with `rs1_d`=0. Required: `rd1_d`=0, array unchanged, count unchanged.
- Illegal: `regwrite_w`=1, `resultsrc_w`=11, `rd_w`=3. Required: x3 unchanged, `illegal_src`=1 and it stays 1 through 5 further legal writes, `wb_count` counts only those 5. Then pulse `rst`. Required: flag clears.
- Wrap: force `wb_count` to 32'hFFFFFFFE, then do 3 commits. Required: the count goes FFFFFFFF, 0, 1.
- Reset mid-stream: during a write burst, assert `rst` on the cycle writing x10=32'h1. Required: x10=0 afterwards and all registers zero.
